lt_prefetch_queue: RTL and testbench

//  Parametrised instruction prefetch unit for the next lt-series core. It sits

---
 rtl/lt_prefetch_queue_if.sv | 21 ++
 rtl/lt_prefetch_queue.sv | 209 ++++++++++++++++++++
 tb/tb_lt_prefetch_queue.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lt_prefetch_queue_if.sv
// lt bus connection for the prefetch unit: request strobe, address and
// byte enables out from the master; completion, read data and fault back.
interface lt_prefetch_queue_if;
  logic        bus_enable;
  logic        bus_wr_en;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_o_data;
  logic        bus_err;

  modport master (
    output bus_enable, bus_wr_en, bus_addr, bus_be,
    input  bus_ready, bus_o_data, bus_err
  );

  modport slave (
    input  bus_enable, bus_wr_en, bus_addr, bus_be,
    output bus_ready, bus_o_data, bus_err
  );
endinterface

// File: rtl/lt_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the core on
// the lt bus and presents {pc, instr, err} entries from a DEPTH-deep FIFO.
// Compressed encodings are skipped, redirects flush, bus faults halt fetch.
module lt_prefetch_queue #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int unsigned    SKIP_C   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [AW-1:0]            out_pc,
  output logic                     out_err,
  input  logic                     out_take,
  output logic [$clog2(DEPTH):0]   level,
  lt_prefetch_queue_if.master      bus
);

  localparam int unsigned    PW      = $clog2(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE = PW'(1);
  localparam logic [PW:0]    LVL_ONE = (PW+1)'(1);
  localparam logic [AW-1:0]  PC_MASK = ~AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_fetch_pc;
  logic            r_discard;
  logic            w_discard_nxt;
  logic            r_bus_enable;
  logic [31:0]     r_bus_addr;

  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_level;
  logic [AW-1:0]   r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];
  logic            r_q_err   [DEPTH];

  logic            w_inflight;
  logic            w_room;
  logic            w_issue;
  logic            w_resp;
  logic            w_keep;
  logic            w_compressed;
  logic            w_push;
  logic            w_pop;

  // Response classification and queue-side handshake decode.
  always_comb begin
    w_inflight   = (r_state == S_REQ) && !r_discard;
    w_room       = (32'(r_level) + 32'(w_inflight)) < DEPTH;
    w_resp       = (r_state == S_REQ) && bus.bus_ready;
    w_keep       = w_resp && !r_discard && !redirect;
    w_compressed = (SKIP_C != 0) && (bus.bus_o_data[1:0] != 2'b11) && !bus.bus_err;
    w_push       = w_keep && !w_compressed;
    w_pop        = out_take && (r_level != '0) && !redirect;
  end

  // Fetch FSM next-state: issue, wait for completion, mandatory idle gap, halt on fault.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_issue       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!redirect && w_room) begin
          w_state_nxt = S_REQ;
          w_issue     = 1'b1;
        end
      end
      S_REQ: begin
        // A redirect never abandons the bus request; it only marks the
        // eventual response for dropping (or drops it in the same cycle).
        if (bus.bus_ready) begin
          w_discard_nxt = 1'b0;
          w_state_nxt   = (w_keep && bus.bus_err) ? S_HALT : S_GAP;
        end else if (redirect) begin
          w_discard_nxt = 1'b1;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      S_HALT: begin
        if (redirect) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and discard flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // Bus request strobe and address, held from issue until completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_enable <= 1'b0;
      r_bus_addr   <= '0;
    end else if (w_issue) begin
      r_bus_enable <= 1'b1;
      r_bus_addr   <= 32'(r_fetch_pc);
    end else if (w_resp) begin
      r_bus_enable <= 1'b0;
    end
  end

  // Sequential fetch address: redirect target, else advance past the accepted parcel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc & PC_MASK;
    end else if (w_keep) begin
      r_fetch_pc <= r_fetch_pc + (w_compressed ? AW'(2) : AW'(4));
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else if (redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_ONE;
      end
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_fetch_pc;
      r_q_instr[r_tail] <= bus.bus_o_data;
      r_q_err[r_tail]   <= bus.bus_err;
    end
  end

  // Head entry presented combinationally, zeroed while the queue is empty.
  always_comb begin
    out_valid = (r_level != '0);
    out_pc    = '0;
    out_instr = '0;
    out_err   = 1'b0;
    if (out_valid) begin
      out_pc    = r_q_pc[r_head];
      out_instr = r_q_instr[r_head];
      out_err   = r_q_err[r_head];
    end
  end

  // Bus outputs: read-only, full-word accesses.
  always_comb begin
    bus.bus_enable = r_bus_enable;
    bus.bus_addr   = r_bus_addr;
    bus.bus_wr_en  = 1'b0;
    bus.bus_be     = '1;
    level          = r_level;
  end

  // Slot reservation at issue guarantees a push always finds room.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (32'(r_level) < DEPTH));

  // Occupancy never exceeds the queue depth.
  a_level_range: assert property (@(posedge clk) disable iff (rst)
    32'(r_level) <= DEPTH);

  // The strobe is low whenever the FSM is not waiting on a request.
  a_enable_req: assert property (@(posedge clk) disable iff (rst)
    r_bus_enable == (r_state == S_REQ));

endmodule

// File: tb/tb_lt_prefetch_queue.sv
// Bench for lt_prefetch_queue: a latency-programmable bus responder feeds a
// scoreboard of expected queue entries; the core side pops and compares.
module tb_lt_prefetch_queue;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   redirect = 1'b0;
  logic [AW-1:0]          redirect_pc = '0;
  logic                   out_take = 1'b0;
  logic                   out_valid;
  logic [31:0]            out_instr;
  logic [AW-1:0]          out_pc;
  logic                   out_err;
  logic [$clog2(DEPTH):0] level;

  lt_prefetch_queue_if bus_if ();

  lt_prefetch_queue #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .SKIP_C   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_err     (out_err),
    .out_take    (out_take),
    .level       (level),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          ov;
    logic [31:0] ovd;
    int          lat;
    logic [31:0] p1;
    logic [31:0] i1;
    logic [31:0] p2;
    logic [31:0] i2;
  } vec_t;

  ent_t        sb[$];
  logic [31:0] flog[$];
  int          n_vec = 0;
  int          n_miss = 0;

  int          lat = 1;
  int          rcnt = 0;
  bit          drop_next = 1'b0;
  bit          ov_en = 1'b0;
  logic [31:0] ov_addr = '0;
  logic [31:0] ov_data = '0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] rsp_a;
  logic [31:0] rsp_d;
  logic        rsp_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ov_en && a == ov_addr) return ov_data;
    return {a[29:0], 2'b11};
  endfunction

  function automatic logic [31:0] flog_at(input int i);
    if (i < flog.size()) return flog[i];
    return 32'hDEAD_0001;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Bus responder: ready 'lat' cycles after the strobe; expected entries are
  // queued here unless the response is known to be discarded or skipped.
  always @(negedge clk) begin
    if (rst) begin
      bus_if.bus_ready  = 1'b0;
      bus_if.bus_err    = 1'b0;
      bus_if.bus_o_data = '0;
      rcnt = 0;
    end else if (bus_if.bus_ready) begin
      bus_if.bus_ready = 1'b0;
      bus_if.bus_err   = 1'b0;
      rcnt = 0;
    end else if (bus_if.bus_enable) begin
      rcnt++;
      if (rcnt >= lat) begin
        rsp_a = bus_if.bus_addr;
        rsp_d = mem_word(rsp_a);
        rsp_e = err_en && (rsp_a == err_addr);
        bus_if.bus_ready  = 1'b1;
        bus_if.bus_o_data = rsp_d;
        bus_if.bus_err    = rsp_e;
        chk("bus_wr_en", 32'(bus_if.bus_wr_en), 32'h0);
        chk("bus_be", 32'(bus_if.bus_be), 32'hF);
        if (drop_next) begin
          drop_next = 1'b0;
        end else begin
          flog.push_back(rsp_a);
          if (rsp_e) sb.push_back('{rsp_a, rsp_d, 1'b1});
          else if (rsp_d[1:0] == 2'b11) sb.push_back('{rsp_a, rsp_d, 1'b0});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!out_valid && t < 200) begin
      step(1);
      t++;
    end
    chk(nm, 32'(out_valid), 32'h1);
  endtask

  task automatic take_one(input string nm);
    ent_t e;
    wait_valid({nm, "_valid"});
    if (sb.size() == 0) begin
      chk({nm, "_sb_size"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_pc"}, 32'(out_pc), e.pc);
      chk({nm, "_instr"}, out_instr, e.instr);
      chk({nm, "_err"}, 32'(out_err), 32'(e.err));
    end
    out_take = 1'b1;
    @(posedge clk);
    #1;
    out_take = 1'b0;
    step(1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    if (bus_if.bus_enable && !bus_if.bus_ready) drop_next = 1'b1;
    sb.delete();
    flog.delete();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_take  = 1'b0;
    redirect  = 1'b0;
    drop_next = 1'b0;
    sb.delete();
    flog.delete();
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vt[6];
    logic [31:0] drain_pc[4];
    int          t;
    int          en_seen;

    vt[0] = '{32'h0000_0200, 1'b0, 32'h0,         1, 32'h0000_0200, 32'h0000_0803, 32'h0000_0204, 32'h0000_0813};
    vt[1] = '{32'h0000_0301, 1'b0, 32'h0,         2, 32'h0000_0300, 32'h0000_0C03, 32'h0000_0304, 32'h0000_0C13};
    vt[2] = '{32'h0000_0400, 1'b1, 32'h1234_5602, 1, 32'h0000_0402, 32'h0000_100B, 32'h0000_0406, 32'h0000_101B};
    vt[3] = '{32'h0000_0500, 1'b1, 32'hCAFE_F00F, 4, 32'h0000_0500, 32'hCAFE_F00F, 32'h0000_0504, 32'h0000_1413};
    vt[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         2, 32'hFFFF_FFFC, 32'hFFFF_FFF3, 32'h0000_0000, 32'h0000_0003};
    vt[5] = '{32'h0001_0000, 1'b1, 32'h0,         3, 32'h0001_0002, 32'h0004_000B, 32'h0001_0006, 32'h0004_001B};
    drain_pc[0] = 32'h4;
    drain_pc[1] = 32'h8;
    drain_pc[2] = 32'hC;
    drain_pc[3] = 32'h10;

    // Reset values
    step(1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", 32'(out_pc), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_bus_enable", 32'(bus_if.bus_enable), 32'h0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_wr_en", 32'(bus_if.bus_wr_en), 32'h0);
    chk("rst_bus_be", 32'(bus_if.bus_be), 32'hF);
    lat = 1;
    rst = 1'b0;

    // T1: fill to DEPTH with no consumer
    step(30);
    chk("t1_level", 32'(level), 32'd4);
    chk("t1_fetch_count", 32'(flog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_fetch_addr", flog_at(i), 32'(i * 4));
    for (int i = 0; i < 5; i++) begin
      chk("t1_enable_idle", 32'(bus_if.bus_enable), 32'h0);
      step(1);
    end

    // T2: one pop triggers exactly one new fetch
    take_one("t2_head");
    step(10);
    chk("t2_fetch_count", 32'(flog.size()), 32'd5);
    chk("t2_fetch_addr", flog_at(4), 32'h10);
    chk("t2_level", 32'(level), 32'd4);
    chk("t2_enable_idle", 32'(bus_if.bus_enable), 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_valid("t2_drain_valid");
      chk("t2_drain_pc", 32'(out_pc), drain_pc[i]);
      take_one("t2_drain");
    end

    // T3: compressed word at the reset PC is skipped
    ov_en = 1'b1; ov_addr = 32'h0; ov_data = 32'h0000_0001;
    do_reset();
    wait_valid("t3_valid");
    chk("t3_head_pc", 32'(out_pc), 32'h2);
    chk("t3_head_instr", out_instr, 32'h0000_000B);
    chk("t3_fetch0", flog_at(0), 32'h0);
    chk("t3_fetch1", flog_at(1), 32'h2);
    take_one("t3_sb");
    ov_en = 1'b0;

    // T4: redirect while a slow request to 0x8 is outstanding
    lat = 3;
    ov_en = 1'b1; ov_addr = 32'h8; ov_data = 32'hDEAD_BEEF;
    do_reset();
    t = 0;
    while (!(bus_if.bus_enable && bus_if.bus_addr == 32'h8) && t < 200) begin
      step(1);
      t++;
    end
    chk("t4_req_at_8", 32'(bus_if.bus_enable && bus_if.bus_addr == 32'h8), 32'h1);
    do_redirect(32'h100);
    chk("t4_level_flushed", 32'(level), 32'h0);
    chk("t4_valid_flushed", 32'(out_valid), 32'h0);
    wait_valid("t4_valid");
    chk("t4_head_pc", 32'(out_pc), 32'h100);
    chk("t4_head_instr", out_instr, 32'h0000_0403);
    chk("t4_first_fetch", flog_at(0), 32'h100);
    take_one("t4_sb");
    ov_en = 1'b0;

    // T4b: response completes in the very cycle of the redirect
    lat = 2;
    t = 0;
    while (!(bus_if.bus_enable && rcnt == 1 && !bus_if.bus_ready) && t < 200) begin
      step(1);
      t++;
    end
    chk("t4b_req_pending", 32'(bus_if.bus_enable), 32'h1);
    step(1);
    do_redirect(32'h180);
    wait_valid("t4b_valid");
    chk("t4b_head_pc", 32'(out_pc), 32'h180);
    chk("t4b_first_fetch", flog_at(0), 32'h180);
    take_one("t4b_sb");

    // Table: redirect targets, alignment, compressed skip, latency, PC wrap
    foreach (vt[k]) begin
      lat     = vt[k].lat;
      ov_en   = vt[k].ov;
      ov_addr = vt[k].pc & 32'hFFFF_FFFE;
      ov_data = vt[k].ovd;
      do_redirect(vt[k].pc);
      wait_valid("vec_valid");
      chk("vec_pc1", 32'(out_pc), vt[k].p1);
      chk("vec_instr1", out_instr, vt[k].i1);
      chk("vec_err1", 32'(out_err), 32'h0);
      chk("vec_first_fetch", flog_at(0), vt[k].pc & 32'hFFFF_FFFE);
      take_one("vec_sb1");
      wait_valid("vec_valid2");
      chk("vec_pc2", 32'(out_pc), vt[k].p2);
      chk("vec_instr2", out_instr, vt[k].i2);
      take_one("vec_sb2");
      ov_en = 1'b0;
    end

    // T5: bus fault is queued in-band and halts fetch until redirect
    lat = 1;
    err_en = 1'b1; err_addr = 32'h4;
    do_reset();
    take_one("t5_first");
    wait_valid("t5_err_valid");
    chk("t5_err_pc", 32'(out_pc), 32'h4);
    chk("t5_err_flag", 32'(out_err), 32'h1);
    chk("t5_err_instr", out_instr, 32'h0000_0013);
    en_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.bus_enable) en_seen++;
      step(1);
    end
    chk("t5_halted_enables", 32'(en_seen), 32'h0);
    chk("t5_level", 32'(level), 32'h1);
    err_en = 1'b0;
    do_redirect(32'h600);
    wait_valid("t5_resume_valid");
    chk("t5_resume_pc", 32'(out_pc), 32'h600);
    chk("t5_resume_err", 32'(out_err), 32'h0);
    take_one("t5_resume_sb");

    // T6: asynchronous reset in the middle of a request with 3 entries queued
    lat = 3;
    do_reset();
    t = 0;
    while (!(32'(level) == 32'd3 && bus_if.bus_enable) && t < 200) begin
      step(1);
      t++;
    end
    chk("t6_setup", 32'(32'(level) == 32'd3 && bus_if.bus_enable), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_async_enable", 32'(bus_if.bus_enable), 32'h0);
    chk("t6_async_level", 32'(level), 32'h0);
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    drop_next = 1'b0;
    sb.delete();
    flog.delete();
    step(2);
    rst = 1'b0;
    wait_valid("t6_restart_valid");
    chk("t6_restart_fetch", flog_at(0), 32'h0);
    chk("t6_restart_pc", 32'(out_pc), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
